// File: rtl/mvm_engine_arbiter.sv
// Round-robin session arbiter that shares one matrix-vector engine between N
// requesters, with a watchdog that resets the engine when a computation hangs.
module mvm_engine_arbiter #(
  parameter int N       = 2,
  parameter int B       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  input  logic [N-1:0]   cmd_load_matrix,
  input  logic [N-1:0]   cmd_load_vector,
  input  logic [N-1:0]   cmd_start,
  input  logic [N*B-1:0] req_data,
  output logic [N-1:0]   done_o,
  output logic [N-1:0]   err_o,
  output logic [2*B-1:0] resp_data,
  output logic           eng_load_matrix,
  output logic           eng_load_vector,
  output logic           eng_start,
  output logic [B-1:0]   eng_data_in,
  output logic           eng_reset,
  input  logic           eng_done,
  input  logic [2*B-1:0] eng_data_out
);
  localparam int IW = $clog2(N);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, OWNED, DRAIN, ABORT} state_t;

  state_t        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] rr;
  logic          busy;
  logic [WW-1:0] wd;

  logic [IW-1:0] pick;
  logic [IW-1:0] idx;
  logic          pick_valid;
  logic [N-1:0]  owner_oh;
  logic [B-1:0]  owner_data;
  logic          fwd_en;
  logic          busy_next;
  logic          timeout;

  // Round-robin search starting at rr; the first requester found wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pick       = '0;
    idx        = '0;
    pick_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(rr) + i) % N);
      if (!pick_valid && req[idx]) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < N; i++) begin
      if (owner == IW'(i)) owner_data = req_data[i*B +: B];
    end
  end

  assign owner_oh = N'(1) << owner;

  // Commands are combinational so the data word stays aligned with its strobe.
  assign fwd_en          = (state == OWNED) && gnt[owner] && !busy;
  assign eng_load_matrix = fwd_en && cmd_load_matrix[owner];
  assign eng_load_vector = fwd_en && cmd_load_vector[owner];
  assign eng_start       = fwd_en && cmd_start[owner];
  assign eng_data_in     = (|gnt) ? owner_data : '0;

  assign done_o    = ((state == OWNED || state == DRAIN) && eng_done) ? owner_oh : '0;
  assign resp_data = eng_data_out;
  assign eng_reset = reset || (state == ABORT);

  // A done arriving in the timeout cycle completes the job instead of aborting.
  assign busy_next = (busy && !eng_done) || eng_start;
  assign timeout   = busy && !eng_done && (wd == WW'(TIMEOUT));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      rr    <= '0;
      busy  <= 1'b0;
      wd    <= '0;
      gnt   <= '0;
      err_o <= '0;
    end else begin
      err_o <= '0;
      busy  <= busy_next;
      if (!busy_next)               wd <= '0;
      else if (wd != WW'(TIMEOUT))  wd <= wd + 1'b1;

      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner <= pick;
            gnt   <= N'(1) << pick;
            rr    <= (pick == IW'(N - 1)) ? '0 : pick + IW'(1);
            state <= OWNED;
          end
        end
        OWNED: begin
          if (timeout) begin
            state <= ABORT;
            gnt   <= '0;
            err_o <= owner_oh;
            busy  <= 1'b0;
            wd    <= '0;
          end else if (!req[owner]) begin
            gnt   <= '0;
            state <= busy_next ? DRAIN : IDLE;
          end
        end
        DRAIN: begin
          if (eng_done) begin
            state <= IDLE;
          end else if (timeout) begin
            state <= ABORT;
            err_o <= owner_oh;
            busy  <= 1'b0;
            wd    <= '0;
          end
        end
        ABORT: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mvm_engine_arbiter.sv
// Directed bench for mvm_engine_arbiter: the bench plays both the requesters
// and the engine; expected values are hand-computed per cycle.
module tb_mvm_engine_arbiter;
  localparam int N = 2;
  localparam int B = 8;
  localparam int TIMEOUT = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   cmd_load_matrix = '0;
  logic [N-1:0]   cmd_load_vector = '0;
  logic [N-1:0]   cmd_start = '0;
  logic [N*B-1:0] req_data = '0;
  logic [N-1:0]   done_o;
  logic [N-1:0]   err_o;
  logic [2*B-1:0] resp_data;
  logic           eng_load_matrix;
  logic           eng_load_vector;
  logic           eng_start;
  logic [B-1:0]   eng_data_in;
  logic           eng_reset;
  logic           eng_done = 1'b0;
  logic [2*B-1:0] eng_data_out = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mvm_engine_arbiter #(.N(N), .B(B), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt),
    .cmd_load_matrix(cmd_load_matrix), .cmd_load_vector(cmd_load_vector),
    .cmd_start(cmd_start), .req_data(req_data), .done_o(done_o), .err_o(err_o),
    .resp_data(resp_data), .eng_load_matrix(eng_load_matrix),
    .eng_load_vector(eng_load_vector), .eng_start(eng_start),
    .eng_data_in(eng_data_in), .eng_reset(eng_reset), .eng_done(eng_done),
    .eng_data_out(eng_data_out)
  );

  // Inputs change and outputs are sampled on the falling edge, away from the
  // rising edge the design uses.
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_dut();
    req = '0; cmd_load_matrix = '0; cmd_load_vector = '0; cmd_start = '0;
    req_data = '0; eng_done = 1'b0; eng_data_out = '0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req = 2'b11; cmd_start = 2'b11; eng_done = 1'b1;
    tick(2); #1;
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rst_gnt: got %b want 00", gnt); end
    total++; if (err_o !== 2'b00) begin bad++; $display("FAIL rst_err: got %b want 00", err_o); end
    total++; if (done_o !== 2'b00) begin bad++; $display("FAIL rst_done: got %b want 00", done_o); end
    total++; if (eng_reset !== 1'b1) begin bad++; $display("FAIL rst_eng_reset: got %b want 1", eng_reset); end
    total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL rst_eng_start: got %b want 0", eng_start); end
    reset = 1'b0; req = '0; cmd_start = '0; eng_done = 1'b0; #1;
    total++; if (eng_reset !== 1'b0) begin bad++; $display("FAIL rst_release: got %b want 0", eng_reset); end
    tick(); #1;
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rst_idle_gnt: got %b want 00", gnt); end
  endtask

  task automatic test_single_grant();
    reset_dut();
    eng_done = 1'b1; req = 2'b01; #1;
    total++; if (done_o !== 2'b00) begin bad++; $display("FAIL sg_idle_done: got %b want 00", done_o); end
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL sg_gnt_early: got %b want 00", gnt); end
    tick(); eng_done = 1'b0; #1;
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL sg_gnt: got %b want 01", gnt); end
    req = 2'b11; cmd_load_matrix = 2'b01; cmd_load_vector = 2'b10; req_data = {8'hAA, 8'h05}; #1;
    total++; if (eng_load_matrix !== 1'b1) begin bad++; $display("FAIL sg_lm: got %b want 1", eng_load_matrix); end
    total++; if (eng_load_vector !== 1'b0) begin bad++; $display("FAIL sg_lv_other: got %b want 0", eng_load_vector); end
    total++; if (eng_data_in !== 8'h05) begin bad++; $display("FAIL sg_data: got %h want 05", eng_data_in); end
    tick(); cmd_load_matrix = '0; cmd_load_vector = '0; cmd_start = 2'b10; #1;
    total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL sg_start_other: got %b want 0", eng_start); end
    tick(); cmd_start = '0; #1;
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL sg_pending: got %b want 01", gnt); end
    req = 2'b10;
    tick(); #1;
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL sg_release: got %b want 00", gnt); end
    total++; if (eng_data_in !== 8'h00) begin bad++; $display("FAIL sg_data_nognt: got %h want 00", eng_data_in); end
    tick(); #1;
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL sg_gnt1: got %b want 10", gnt); end
    total++; if (eng_data_in !== 8'hAA) begin bad++; $display("FAIL sg_data1: got %h want aa", eng_data_in); end
    req = '0;
    tick(2);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    reset_dut();
    req = 2'b11;
    tick(); #1;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      total++; if (gnt !== exp_g) begin bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt, exp_g); end
      req = 2'b11 & ~exp_g;
      tick(); #1;
      total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rr_gap[%0d]: got %b want 00", i, gnt); end
      req = 2'b11;
      tick(); #1;
    end
    req = '0;
    tick(2);
  endtask

  task automatic test_normal_compute();
    reset_dut();
    req = 2'b01;
    tick();
    cmd_start = 2'b01; req_data = 16'h0007; #1;
    total++; if (eng_start !== 1'b1) begin bad++; $display("FAIL nc_start: got %b want 1", eng_start); end
    total++; if (eng_data_in !== 8'h07) begin bad++; $display("FAIL nc_data: got %h want 07", eng_data_in); end
    tick();
    cmd_load_matrix = 2'b01; #1;
    total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL nc_start_masked: got %b want 0", eng_start); end
    total++; if (eng_load_matrix !== 1'b0) begin bad++; $display("FAIL nc_lm_masked: got %b want 0", eng_load_matrix); end
    tick(); cmd_start = '0; cmd_load_matrix = '0;
    tick(28);
    eng_done = 1'b1; eng_data_out = 16'h1234; #1;
    total++; if (done_o !== 2'b01) begin bad++; $display("FAIL nc_done: got %b want 01", done_o); end
    total++; if (resp_data !== 16'h1234) begin bad++; $display("FAIL nc_resp: got %h want 1234", resp_data); end
    total++; if (err_o !== 2'b00) begin bad++; $display("FAIL nc_err: got %b want 00", err_o); end
    tick(); eng_done = 1'b0; cmd_load_vector = 2'b01; #1;
    total++; if (done_o !== 2'b00) begin bad++; $display("FAIL nc_done_pulse: got %b want 00", done_o); end
    total++; if (eng_load_vector !== 1'b1) begin bad++; $display("FAIL nc_unmasked: got %b want 1", eng_load_vector); end
    tick(); cmd_load_vector = '0; req = '0;
    tick(2);
  endtask

  task automatic test_drain();
    reset_dut();
    req = 2'b11;
    tick(); #1;
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL dr_gnt: got %b want 01", gnt); end
    cmd_start = 2'b01;
    tick(); cmd_start = '0; req = 2'b10; #1;
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL dr_gnt_hold: got %b want 01", gnt); end
    tick(); #1;
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL dr_gnt_drop: got %b want 00", gnt); end
    tick(2);
    eng_done = 1'b1; #1;
    total++; if (done_o !== 2'b01) begin bad++; $display("FAIL dr_done: got %b want 01", done_o); end
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL dr_no_early_gnt: got %b want 00", gnt); end
    tick(); eng_done = 1'b0; #1;
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL dr_idle: got %b want 00", gnt); end
    tick(); #1;
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL dr_next: got %b want 10", gnt); end
    req = '0;
    tick(2);
  endtask

  task automatic test_drop_with_start();
    reset_dut();
    req = 2'b01;
    tick();
    req = 2'b00; cmd_start = 2'b01; #1;
    total++; if (eng_start !== 1'b1) begin bad++; $display("FAIL ds_start: got %b want 1", eng_start); end
    tick(); cmd_start = '0; #1;
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL ds_gnt: got %b want 00", gnt); end
    eng_done = 1'b1; #1;
    total++; if (done_o !== 2'b01) begin bad++; $display("FAIL ds_done: got %b want 01", done_o); end
    tick(); eng_done = 1'b0;
    tick();
  endtask

  // The 64th busy cycle after start is where the timeout is judged; with no
  // done there, the one-cycle abort follows on the next cycle.
  task automatic test_timeout();
    reset_dut();
    req = 2'b01;
    tick();
    cmd_start = 2'b01;
    tick(); cmd_start = '0;
    tick(63); #1;
    total++; if (eng_reset !== 1'b0) begin bad++; $display("FAIL to_early_reset: got %b want 0", eng_reset); end
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL to_early_gnt: got %b want 01", gnt); end
    tick(); #1;
    total++; if (eng_reset !== 1'b1) begin bad++; $display("FAIL to_reset: got %b want 1", eng_reset); end
    total++; if (err_o !== 2'b01) begin bad++; $display("FAIL to_err: got %b want 01", err_o); end
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL to_gnt: got %b want 00", gnt); end
    tick(); #1;
    total++; if (eng_reset !== 1'b0) begin bad++; $display("FAIL to_reset_pulse: got %b want 0", eng_reset); end
    total++; if (err_o !== 2'b00) begin bad++; $display("FAIL to_err_pulse: got %b want 00", err_o); end
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL to_idle: got %b want 00", gnt); end
    tick(); #1;
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL to_regrant: got %b want 01", gnt); end
    cmd_start = 2'b01;
    tick(); cmd_start = '0;
    tick(63);
    eng_done = 1'b1; #1;
    total++; if (done_o !== 2'b01) begin bad++; $display("FAIL to_done64: got %b want 01", done_o); end
    tick(); eng_done = 1'b0; #1;
    total++; if (eng_reset !== 1'b0) begin bad++; $display("FAIL to_no_abort: got %b want 0", eng_reset); end
    total++; if (err_o !== 2'b00) begin bad++; $display("FAIL to_no_err: got %b want 00", err_o); end
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL to_still_owned: got %b want 01", gnt); end
    req = '0;
    tick(2);
  endtask

  task automatic test_reset_mid();
    reset_dut();
    req = 2'b11;
    tick();
    cmd_start = 2'b01;
    tick(); cmd_start = '0;
    tick(3);
    reset = 1'b1; #1;
    total++; if (eng_reset !== 1'b1) begin bad++; $display("FAIL rm_eng_reset: got %b want 1", eng_reset); end
    tick(); #1;
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rm_gnt: got %b want 00", gnt); end
    reset = 1'b0; #1;
    total++; if (eng_reset !== 1'b0) begin bad++; $display("FAIL rm_release: got %b want 0", eng_reset); end
    tick(); #1;
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rm_first: got %b want 01", gnt); end
    cmd_start = 2'b01; #1;
    total++; if (eng_start !== 1'b1) begin bad++; $display("FAIL rm_busy_cleared: got %b want 1", eng_start); end
    tick(); cmd_start = '0; req = '0; eng_done = 1'b1;
    tick(); eng_done = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_normal_compute();
    test_drain();
    test_drop_with_start();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
